// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin system-bus arbiter.
// Provides the FSM state enum, default timeout and rotating first-set-bit search.
package bus_arb_pkg;

   localparam int MAX_MASTERS            = 8;
   localparam int DEFAULT_TIMEOUT_CYCLES = 256;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_BUSY,
      ST_RELEASE
   } arb_state_t;

   // First set bit of req searching from ptr+1 upward, wrapping at n.
   // Returns ptr when req is empty; callers qualify with |req.
   function automatic logic [2:0] rr_first_idx(
      input logic [MAX_MASTERS-1:0] req,
      input logic [2:0]             ptr,
      input int                     n
   );
      int   cand;
      logic found;
      rr_first_idx = ptr;
      found        = 1'b0;
      for (int i = 1; i <= MAX_MASTERS; i++) begin
         cand = (int'(ptr) + i) % n;
         if (i <= n && !found && req[cand]) begin
            rr_first_idx = 3'(cand);
            found        = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: winner after the pointer, wrapping.
// Ports: request/pointer in; winner_onehot, winner_idx, winner_valid out.
module rr_priority_picker
   import bus_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 4
) (
   input  logic [NUM_MASTERS-1:0] request,
   input  logic [2:0]             pointer,
   output logic [NUM_MASTERS-1:0] winner_onehot,
   output logic [2:0]             winner_idx,
   output logic                   winner_valid
);

   logic [MAX_MASTERS-1:0] req_ext;

   assign winner_valid = |request;

   always_comb begin
      req_ext                    = '0;
      req_ext[NUM_MASTERS-1:0]   = request;
      winner_idx                 = rr_first_idx(req_ext, pointer, NUM_MASTERS);
      winner_onehot              = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         winner_onehot[i] = winner_valid && (winner_idx == 3'(i));
      end
   end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin system-bus arbiter holding one grant per bus transaction.
// Ports: clock, reset (async high), request/granted per master,
// begin/end/error bus strobes in, bus_idle and errorOUT out.
// Optional macro BUS_ARB_TIMEOUT_EN adds the grant/busy timeout counter.
module bus_arbiter_rr
   import bus_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 4,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] request,
   output logic [NUM_MASTERS-1:0] granted,
   input  logic                   begin_transactionIN,
   input  logic                   end_transactionIN,
   input  logic                   errorIN,
   output logic                   bus_idle,
   output logic                   errorOUT
);

   if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS ||
       TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("bus_arbiter_rr: unsupported configuration");
   end

   arb_state_t             state;
   logic [2:0]             ptr;
   logic [2:0]             served_idx;
   logic [NUM_MASTERS-1:0] pick_onehot;
   logic [2:0]             pick_idx;
   logic                   pick_valid;
   logic                   req_held;
   logic                   grant_expire;
   logic                   busy_expire;

   rr_priority_picker #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_picker (
      .request       (request),
      .pointer       (ptr),
      .winner_onehot (pick_onehot),
      .winner_idx    (pick_idx),
      .winner_valid  (pick_valid)
   );

   // Granted master still asking for the bus.
   assign req_held = |(request & granted);

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] tmo_cnt;

   // Counts GRANT cycles, restarts on begin, then counts BUSY cycles.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tmo_cnt  <= '0;
         errorOUT <= 1'b0;
      end else begin
         errorOUT <= (state == ST_BUSY) && (tmo_cnt == CNT_LAST) &&
                     !end_transactionIN && !errorIN;
         if (state == ST_GRANT && begin_transactionIN) begin
            tmo_cnt <= '0;
         end else if (state == ST_GRANT || state == ST_BUSY) begin
            if (tmo_cnt != CNT_MAX) begin
               tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
         end else begin
            tmo_cnt <= '0;
         end
      end
   end

   // Busy expiry waits one cycle after the errorOUT pulse.
   assign grant_expire = (state == ST_GRANT) && (tmo_cnt == CNT_LAST);
   assign busy_expire  = (state == ST_BUSY) && (tmo_cnt == CNT_MAX);
`else
   assign grant_expire = 1'b0;
   assign busy_expire  = 1'b0;
   assign errorOUT     = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         granted    <= '0;
         bus_idle   <= 1'b1;
         ptr        <= 3'(NUM_MASTERS - 1);
         served_idx <= 3'(NUM_MASTERS - 1);
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  granted    <= pick_onehot;
                  served_idx <= pick_idx;
                  bus_idle   <= 1'b0;
                  state      <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (begin_transactionIN &&
                   (end_transactionIN || errorIN)) begin
                  granted <= '0;
                  state   <= ST_RELEASE;
               end else if (begin_transactionIN) begin
                  state   <= ST_BUSY;
               end else if (errorIN || !req_held || grant_expire) begin
                  granted <= '0;
                  state   <= ST_RELEASE;
               end
            end
            ST_BUSY: begin
               if (end_transactionIN || errorIN || busy_expire) begin
                  granted <= '0;
                  state   <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               ptr      <= served_idx;
               bus_idle <= 1'b1;
               state    <= ST_IDLE;
            end
            default: begin
               granted  <= '0;
               bus_idle <= 1'b1;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   // A master may only start a transfer once it holds the bus.
   a_no_begin_idle: assert property (@(posedge clock) disable iff (reset)
      !(state == ST_IDLE && begin_transactionIN));

   a_grant_onehot0: assert property (@(posedge clock) disable iff (reset)
      $onehot0(granted));

   a_grant_state: assert property (@(posedge clock) disable iff (reset)
      (granted != '0) |-> (state == ST_GRANT || state == ST_BUSY));

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed steps plus a
// randomized transaction loop against a round-robin reference model.
module tb_bus_arbiter_rr;

   localparam int N = 4;
`ifdef BUS_ARB_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 256;
`endif

   logic         clock = 1'b0;
   logic         reset;
   logic [N-1:0] request;
   logic [N-1:0] granted;
   logic         begin_t;
   logic         end_t;
   logic         err_in;
   logic         bus_idle;
   logic         err_out;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   bus_arbiter_rr #(
      .NUM_MASTERS    (N),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .request             (request),
      .granted             (granted),
      .begin_transactionIN (begin_t),
      .end_transactionIN   (end_t),
      .errorIN             (err_in),
      .bus_idle            (bus_idle),
      .errorOUT            (err_out)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      request = '0;
      begin_t = 1'b0;
      end_t   = 1'b0;
      err_in  = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Reference: next requester strictly after the last one served.
   function automatic int rr_expect(input int last, input logic [N-1:0] req);
      for (int k = 1; k <= N; k++) begin
         if (req[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   initial begin
      int           w;
      int           last;
      int           z;
      int           kind;
      int           hold;
      int           nb;
      logic         bad;
      logic [N-1:0] req;

      do_reset();
      check("rst_granted", granted, 0);
      check("rst_idle", bus_idle, 1);
      check("rst_errout", err_out, 0);

      // single master, 1-cycle grant latency, end 3 cycles after begin
      request = 4'b0100;
      tick();
      check("lat_grant", granted, 4'b0100);
      check("lat_busidle", bus_idle, 0);
      begin_t = 1'b1;
      tick();
      begin_t = 1'b0;
      request = '0;
      tick();
      tick();
      end_t = 1'b1;
      tick();
      end_t = 1'b0;
      check("end_release", granted, 0);
      check("end_notidle", bus_idle, 0);
      tick();
      check("end_idle", bus_idle, 1);

      // fairness with all masters requesting
      do_reset();
      request = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         z = 0;
         while (granted == '0 && z < 8) begin
            tick();
            z++;
         end
         check("fair_grant", granted, 1 << (t % N));
         if (t > 0) check("fair_gap", z, 2);
         begin_t = 1'b1;
         tick();
         begin_t = 1'b0;
         end_t   = 1'b1;
         tick();
         end_t = 1'b0;
         check("fair_release", granted, 0);
      end

      // master 1 drops request before begin; pointer moves to 1
      do_reset();
      request = 4'b0010;
      tick();
      check("drop_grant", granted, 4'b0010);
      request = 4'b1001;
      tick();
      check("drop_release", granted, 0);
      tick();
      check("drop_idle", bus_idle, 1);
      tick();
      check("drop_ptr", granted, 4'b1000);

      // error during busy
      begin_t = 1'b1;
      tick();
      begin_t = 1'b0;
      request = 4'b0011;
      tick();
      err_in = 1'b1;
      tick();
      err_in = 1'b0;
      check("busyerr_release", granted, 0);
      tick();
      tick();
      check("busyerr_next", granted, 4'b0001);

      // error during grant
      err_in = 1'b1;
      tick();
      err_in = 1'b0;
      check("granterr_release", granted, 0);
      tick();
      tick();
      check("granterr_next", granted, 4'b0010);

      // single-cycle transfer
      begin_t = 1'b1;
      end_t   = 1'b1;
      tick();
      begin_t = 1'b0;
      end_t   = 1'b0;
      request = '0;
      check("single_release", granted, 0);
      tick();
      check("single_idle", bus_idle, 1);

      // error strobe while idle is ignored
      err_in = 1'b1;
      tick();
      err_in = 1'b0;
      check("idleerr_granted", granted, 0);
      check("idleerr_idle", bus_idle, 1);

      // long transaction: timeout or indefinite hold
      request = 4'b0100;
      tick();
      check("long_grant", granted, 4'b0100);
      begin_t = 1'b1;
      tick();
      begin_t = 1'b0;
      request = '0;
`ifdef BUS_ARB_TIMEOUT_EN
      bad = 1'b0;
      for (int i = 1; i < TMO; i++) begin
         tick();
         if (err_out !== 1'b0 || granted !== 4'b0100) bad = 1'b1;
      end
      check("tmo_quiet", bad, 0);
      tick();
      check("tmo_pulse", err_out, 1);
      check("tmo_pulse_grant", granted, 4'b0100);
      tick();
      check("tmo_pulse_end", err_out, 0);
      check("tmo_release", granted, 0);
      tick();
      check("tmo_idle", bus_idle, 1);
      request = 4'b1000;
      tick();
      check("gtmo_grant", granted, 4'b1000);
      for (int i = 1; i < TMO; i++) tick();
      check("gtmo_held", granted, 4'b1000);
      tick();
      check("gtmo_release", granted, 0);
      check("gtmo_noerr", err_out, 0);
      request = '0;
      tick();
`else
      bad = 1'b0;
      for (int i = 0; i < 120; i++) begin
         tick();
         if (err_out !== 1'b0 || granted !== 4'b0100) bad = 1'b1;
      end
      check("hold_120", bad, 0);
      end_t = 1'b1;
      tick();
      end_t = 1'b0;
      check("hold_release", granted, 0);
      tick();
`endif

      // randomized transactions against the reference model
      do_reset();
      last = N - 1;
      for (int it = 0; it < 60; it++) begin
         req     = N'($urandom_range(1, (1 << N) - 1));
         request = req;
         tick();
         w = rr_expect(last, req);
         check("rnd_grant", granted, 1 << w);
         hold = $urandom_range(0, 2);
         for (int h = 0; h < hold; h++) begin
            tick();
            check("rnd_hold", granted, 1 << w);
         end
         kind = $urandom_range(0, 4);
         case (kind)
            0: begin
               begin_t = 1'b1;
               end_t   = 1'b1;
               tick();
               begin_t = 1'b0;
               end_t   = 1'b0;
            end
            1, 2: begin
               begin_t = 1'b1;
               tick();
               begin_t = 1'b0;
               nb = $urandom_range(0, 3);
               for (int b = 0; b < nb; b++) begin
                  request = N'($urandom_range(0, (1 << N) - 1));
                  tick();
                  check("rnd_busy", granted, 1 << w);
               end
               if (kind == 1) end_t = 1'b1;
               else err_in = 1'b1;
               tick();
               end_t  = 1'b0;
               err_in = 1'b0;
            end
            3: begin
               request = req & ~N'(1 << w);
               tick();
            end
            default: begin
               err_in = 1'b1;
               tick();
               err_in = 1'b0;
            end
         endcase
         check("rnd_release", granted, 0);
         request = '0;
         tick();
         check("rnd_idle", bus_idle, 1);
         last = w;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
